// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: funct3 encodings and FSM state type shared by the load/store unit.
package rv32i_mem_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} mau_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: load lane extraction/extension and sub-word store merge.
module mem_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] ldata,
  output logic [31:0] mword
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    ldata = funct3 == F3_B  ? {{24{b[7]}}, b} :
            funct3 == F3_BU ? {24'b0, b} :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_HU ? {16'b0, h} : word;
    mword = word;
    if (funct3 == F3_B) mword[8*lane +: 8] = wdata[7:0];
    else if (funct3 == F3_H) mword[16*lane[1] +: 16] = wdata[15:0];
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store initiator for a word-wide RAM without byte enables.
module mem_access_unit
  import rv32i_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [MEM_WIDTH-1:0]  req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [MEM_WIDTH-1:0]  resp_rdata,
  output logic                  resp_err,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [MEM_WIDTH-1:0]  ram_wdata,
  input  logic [MEM_WIDTH-1:0]  ram_rdata
);
  mau_state_t state, state_n;
  logic                  wr, err, bad, accept;
  logic [2:0]            f3;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           wd, rword, rdata, ldata, mword;
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
  assign bad = (|req_addr[31:ADDR_WIDTH+2]) ||
               ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
               (req_funct3 == F3_W && |req_addr[1:0]) ||
               (req_write ? req_funct3 > F3_W : req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = bad ? RESP : (req_write && req_funct3 == F3_W) ? WRITE : READ;
      READ:    state_n = wr ? WRITE : RESP;
      WRITE:   state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wr    <= 1'b0;
      f3    <= '0;
      lane  <= '0;
      idx   <= '0;
      wd    <= '0;
      rword <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        wr    <= req_write;
        f3    <= req_funct3;
        lane  <= req_addr[1:0];
        idx   <= req_addr[ADDR_WIDTH+1:2];
        wd    <= req_wdata;
        err   <= bad;
        rdata <= '0;
      end
      if (state == READ) begin
        rword <= ram_rdata;
        if (!wr) rdata <= ldata;
      end
    end
  end
  // READ aligns the live RAM word; WRITE merges into the word captured in READ
  mem_lane_align u_align (
    .word   (state == READ ? ram_rdata : rword),
    .wdata  (wd),
    .funct3 (f3),
    .lane   (lane),
    .ldata  (ldata),
    .mword  (mword)
  );
  assign ram_ren    = rst_n && state == READ;
  assign ram_wen    = rst_n && state == WRITE;
  assign ram_raddr  = idx;
  assign ram_waddr  = idx;
  assign ram_wdata  = state == WRITE ? (f3 == F3_W ? wd : mword) : '0;
  assign resp_valid = state == RESP;
  assign resp_rdata = rdata;
  assign resp_err   = err;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks against a behavioural load/store model.
module tb_mem_access_unit;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, req_write = 0, resp_valid, resp_ready = 0, resp_err;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata, ram_wdata, ram_rdata;
  logic        ram_wen, ram_ren;
  logic [7:0]  ram_waddr, ram_raddr;
  logic [31:0] ram [256];
  logic [31:0] refm [256];
  int nvec = 0, nfail = 0;
  int wr_cnt = 0, rd_cnt = 0, ovl_cnt = 0;
  logic [7:0]  last_wa = 0;
  logic [31:0] last_wd = 0;

  mem_access_unit #(.MEM_DEPTH(256), .MEM_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  assign ram_rdata = ram[ram_raddr];
  always @(posedge clk) begin
    if (ram_wen) begin
      ram[ram_waddr] <= ram_wdata;
      last_wa <= ram_waddr;
      last_wd <= ram_wdata;
    end
    wr_cnt  <= wr_cnt + int'(ram_wen);
    rd_cnt  <= rd_cnt + int'(ram_ren);
    ovl_cnt <= ovl_cnt + int'(ram_wen && ram_ren);
  end

  task automatic run_txn(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic e);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_write = w; req_funct3 = f; req_addr = a; req_wdata = d;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid = 0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    rd = resp_rdata; e = resp_err;
    resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    nvec++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin nfail++; $display("FAIL reset_resp got err=%b rdata=%h want 0/0", resp_err, resp_rdata); end
    nvec++; if (ram_wen !== 1'b0 || ram_ren !== 1'b0) begin nfail++; $display("FAIL reset_ram got wen=%b ren=%b want 0/0", ram_wen, ram_ren); end
    nvec++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    rst_n = 1;
  endtask

  task automatic test_store_word();
    int lat, w0, r0; logic [31:0] rd; logic e;
    w0 = wr_cnt; r0 = rd_cnt;
    run_txn(1, 3'd2, 32'h10, 32'hDEADBEEF, lat, rd, e);
    nvec++; if (lat != 2 || e !== 1'b0) begin nfail++; $display("FAIL sw_lat_err got lat=%0d err=%b want 2/0", lat, e); end
    nvec++; if (wr_cnt - w0 != 1 || rd_cnt != r0) begin nfail++; $display("FAIL sw_ram_ops got wr=%0d rd=%0d want 1/0", wr_cnt - w0, rd_cnt - r0); end
    nvec++; if (last_wa !== 8'd4 || last_wd !== 32'hDEADBEEF) begin nfail++; $display("FAIL sw_write got addr=%0d data=%h want 4/deadbeef", last_wa, last_wd); end
    run_txn(0, 3'd2, 32'h10, 32'h0, lat, rd, e);
    nvec++; if (lat != 2 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL lw got lat=%0d err=%b data=%h want 2/0/deadbeef", lat, e, rd); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] a [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] x [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    int lat; logic [31:0] rd; logic e;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, f[i], a[i], 32'h0, lat, rd, e);
      nvec++; if (rd !== x[i] || e !== 1'b0 || lat != 2) begin nfail++; $display("FAIL load_ext%0d got data=%h err=%b lat=%0d want %h/0/2", i, rd, e, lat, x[i]); end
    end
  endtask

  task automatic test_sub_word_store();
    int lat, w0, r0; logic [31:0] rd; logic e;
    w0 = wr_cnt; r0 = rd_cnt;
    run_txn(1, 3'd0, 32'h11, 32'h55, lat, rd, e);
    nvec++; if (lat != 3 || e !== 1'b0 || rd !== 32'h0) begin nfail++; $display("FAIL sb_resp got lat=%0d err=%b data=%h want 3/0/0", lat, e, rd); end
    nvec++; if (wr_cnt - w0 != 1 || rd_cnt - r0 != 1) begin nfail++; $display("FAIL sb_ram_ops got wr=%0d rd=%0d want 1/1", wr_cnt - w0, rd_cnt - r0); end
    nvec++; if (last_wa !== 8'd4 || last_wd !== 32'hDEAD55EF) begin nfail++; $display("FAIL sb_merge got addr=%0d data=%h want 4/dead55ef", last_wa, last_wd); end
    run_txn(1, 3'd1, 32'h12, 32'h1234, lat, rd, e);
    nvec++; if (lat != 3 || last_wd !== 32'h123455EF) begin nfail++; $display("FAIL sh_merge got lat=%0d data=%h want 3/123455ef", lat, last_wd); end
  endtask

  task automatic test_errors();
    logic        w [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f [4] = '{3'd2, 3'd1, 3'd0, 3'd3};
    logic [31:0] a [4] = '{32'h2, 32'h1, 32'h400, 32'h8};
    int lat, w0, r0; logic [31:0] rd; logic e;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      run_txn(w[i], f[i], a[i], 32'hFFFFFFFF, lat, rd, e);
      nvec++; if (lat != 1 || e !== 1'b1 || rd !== 32'h0) begin nfail++; $display("FAIL err%0d got lat=%0d err=%b data=%h want 1/1/0", i, lat, e, rd); end
      nvec++; if (wr_cnt != w0 || rd_cnt != r0) begin nfail++; $display("FAIL err%0d_ram got wr=%0d rd=%0d want 0/0", i, wr_cnt - w0, rd_cnt - r0); end
    end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd, held; logic e;
    run_txn(1, 3'd2, 32'h20, 32'hCAFEF00D, lat, rd, e);
    @(negedge clk);
    req_valid = 1; req_write = 0; req_funct3 = 3'd2; req_addr = 32'h20;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk); @(negedge clk);
    held = resp_rdata;
    nvec++; if (resp_valid !== 1'b1 || held !== 32'hCAFEF00D) begin nfail++; $display("FAIL hold_first got valid=%b data=%h want 1/cafef00d", resp_valid, held); end
    req_valid = 1; req_funct3 = 3'd2; req_addr = 32'h2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nvec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D || resp_err !== 1'b0 || req_ready !== 1'b0) begin nfail++; $display("FAIL hold_cycle%0d got valid=%b data=%h err=%b ready=%b want 1/cafef00d/0/0", i, resp_valid, resp_rdata, resp_err, req_ready); end
    end
    resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
    @(negedge clk);
    nvec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin nfail++; $display("FAIL hold_release got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    nvec++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin nfail++; $display("FAIL hold_next got valid=%b err=%b want 1/1", resp_valid, resp_err); end
    resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
  endtask

  task automatic test_reset_in_write();
    int lat, w0; logic [31:0] rd; logic e;
    run_txn(1, 3'd2, 32'h14, 32'h11223344, lat, rd, e);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_funct3 = 3'd0; req_addr = 32'h14; req_wdata = 32'hAA;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk);
    @(negedge clk);
    nvec++; if (ram_wen !== 1'b1) begin nfail++; $display("FAIL rstw_in_write got wen=%b want 1", ram_wen); end
    rst_n = 0;
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    nvec++; if (wr_cnt != w0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin nfail++; $display("FAIL rstw_abort got writes=%0d valid=%b ready=%b want 0/0/1", wr_cnt - w0, resp_valid, req_ready); end
    rst_n = 1;
    run_txn(0, 3'd2, 32'h14, 32'h0, lat, rd, e);
    nvec++; if (rd !== 32'h11223344) begin nfail++; $display("FAIL rstw_word got %h want 11223344", rd); end
  endtask

  task automatic test_random();
    int lat, w0, r0, sh, xlat, xw, xr; logic [31:0] rd, a, d, wd, x, nw; logic e, xe, w; logic [2:0] f; logic [7:0] b; logic [15:0] h; int id;
    for (int i = 0; i < 32; i++) begin
      id = i < 16 ? i : i + 224;
      d = $urandom;
      run_txn(1, 3'd2, 32'(id * 4), d, lat, rd, e);
      refm[id] = d;
    end
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      id = $urandom_range(0, 31);
      id = id < 16 ? id : id + 224;
      a = 32'(id * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 4194303)) << 10);
      d = $urandom;
      xe = (a >> 10) != 0 || ((f == 1 || f == 5) && a[0]) || (f == 2 && a[1:0] != 0) || (w ? f >= 3 : (f == 3 || f >= 6));
      wd = refm[id];
      sh = 8 * a[1:0];
      b = 8'(wd >> sh);
      h = 16'(wd >> (16 * a[1]));
      x = 0; nw = wd;
      if (!xe && !w) x = f == 0 ? 32'($signed(b)) : f == 4 ? {24'b0, b} : f == 1 ? 32'($signed(h)) : f == 5 ? {16'b0, h} : wd;
      if (!xe && w) nw = f == 2 ? d : f == 0 ? (wd & ~(32'hFF << sh)) | ((d & 32'hFF) << sh) : (wd & ~(32'hFFFF << (16 * a[1]))) | ((d & 32'hFFFF) << (16 * a[1]));
      xlat = xe ? 1 : (!w || f == 2) ? 2 : 3;
      xw = (xe || !w) ? 0 : 1;
      xr = (xe || (w && f == 2)) ? 0 : 1;
      w0 = wr_cnt; r0 = rd_cnt;
      run_txn(w, f, a, d, lat, rd, e);
      nvec++; if (e !== xe || lat != xlat || rd !== x) begin nfail++; $display("FAIL rnd%0d w=%b f=%0d a=%h got err=%b lat=%0d data=%h want %b/%0d/%h", i, w, f, a, e, lat, rd, xe, xlat, x); end
      nvec++; if (wr_cnt - w0 != xw || rd_cnt - r0 != xr) begin nfail++; $display("FAIL rnd%0d_ops got wr=%0d rd=%0d want %0d/%0d", i, wr_cnt - w0, rd_cnt - r0, xw, xr); end
      if (xw == 1) begin
        nvec++; if (last_wa !== 8'(id) || last_wd !== nw) begin nfail++; $display("FAIL rnd%0d_wr got addr=%0d data=%h want %0d/%h", i, last_wa, last_wd, id, nw); end
      end
      refm[id] = nw;
    end
    nvec++; if (ovl_cnt != 0) begin nfail++; $display("FAIL ren_wen_overlap got %0d want 0", ovl_cnt); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_extend();
    test_sub_word_store();
    test_errors();
    test_hold();
    test_reset_in_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
